// File: rtl/rodata_loader.sv
// rodata_loader: packs a valid/ready byte stream into little-endian words and
// writes them, with address and byte strobes, into the ROM image write port.
module rodata_loader #(
    parameter int XLEN = 32,
    parameter int BYTE_WIDTH = 8,
    parameter int DATA_WIDTH = XLEN,
    parameter logic [XLEN-1:0] BASE_ADDR = '0,
    parameter int MEM_SIZE = 4096,
    localparam int N = DATA_WIDTH / BYTE_WIDTH,
    localparam int CW = $clog2(MEM_SIZE / N) + 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic                  i_byte_valid,
    input  logic [BYTE_WIDTH-1:0] i_byte,
    input  logic                  i_byte_last,
    output logic                  o_byte_ready,
    output logic                  o_we,
    output logic [XLEN-1:0]       o_waddr,
    output logic [DATA_WIDTH-1:0] o_wdata,
    output logic [N-1:0]          o_wstrb,
    input  logic                  i_wready,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_overflow,
    output logic [CW-1:0]         o_word_count
);
    localparam int LW = (N > 1) ? $clog2(N) : 1;
    localparam logic [XLEN-1:0] END_ADDR = BASE_ADDR + XLEN'(MEM_SIZE);

    typedef enum logic [2:0] {IDLE, COLLECT, WRITE, DRAIN, DONE} state_t;

    state_t                state_q, state_d;
    logic [LW-1:0]         lane_q, lane_d;
    logic [XLEN-1:0]       addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [N-1:0]          wstrb_q, wstrb_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  ovf_q, ovf_d;
    logic                  last_q, last_d;
    logic                  word_end;

    assign word_end     = (lane_q == LW'(N - 1)) || i_byte_last;
    assign o_byte_ready = (state_q == COLLECT) || (state_q == DRAIN);
    assign o_we         = state_q == WRITE;
    assign o_busy       = (state_q == COLLECT) || (state_q == WRITE) || (state_q == DRAIN);
    assign o_done       = state_q == DONE;
    assign o_waddr      = addr_q;
    assign o_wdata      = wdata_q;
    assign o_wstrb      = wstrb_q;
    assign o_word_count = cnt_q;
    assign o_overflow   = ovf_q;

    always_comb begin
        state_d = state_q;
        lane_d  = lane_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        last_d  = last_q;
        case (state_q)
            IDLE, DONE: if (i_start) begin
                state_d = COLLECT;
                lane_d  = '0;
                addr_d  = BASE_ADDR;
                wdata_d = '0;
                wstrb_d = '0;
                cnt_d   = '0;
                ovf_d   = 1'b0;
                last_d  = 1'b0;
            end
            COLLECT: if (i_byte_valid) begin
                wdata_d[lane_q*BYTE_WIDTH +: BYTE_WIDTH] = i_byte;
                wstrb_d[lane_q] = 1'b1;
                last_d  = i_byte_last;
                state_d = word_end ? WRITE : COLLECT;
                lane_d  = word_end ? '0 : lane_q + 1'b1;
            end
            // Last flag wins over the capacity check so an exact fit never drains.
            WRITE: if (i_wready) begin
                cnt_d   = cnt_q + 1'b1;
                addr_d  = addr_q + XLEN'(N);
                wdata_d = '0;
                wstrb_d = '0;
                state_d = last_q ? DONE : (addr_q + XLEN'(N) == END_ADDR) ? DRAIN : COLLECT;
            end
            DRAIN: if (i_byte_valid) begin
                ovf_d   = 1'b1;
                state_d = i_byte_last ? DONE : DRAIN;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            lane_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            last_q  <= last_d;
        end
    end
endmodule

// File: tb/tb_rodata_loader.sv
// tb_rodata_loader: randomized scoreboard bench for rodata_loader with 32-bit
// words, base 0 and a 16-byte region.
module tb_rodata_loader;
    typedef logic [7:0] bq_t[$];
    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  s;
    } wr_t;

    logic        clk = 0, rst = 1, start = 0, bvalid = 0, blast = 0, wready = 0;
    logic [7:0]  bdata = 0;
    logic        bready, we, busy, done, ovf;
    logic [31:0] waddr, wdata;
    logic [3:0]  wstrb;
    logic [2:0]  wc;

    int  n_cmp = 0, n_err = 0;
    int  wr_mode = 0;
    wr_t exp_q[$];
    logic        stall_prev = 0;
    logic [31:0] sa, sd;
    logic [3:0]  ss;

    rodata_loader #(.DATA_WIDTH(32), .BASE_ADDR(32'h0), .MEM_SIZE(16)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_byte_valid(bvalid),
        .i_byte(bdata), .i_byte_last(blast), .o_byte_ready(bready), .o_we(we),
        .o_waddr(waddr), .o_wdata(wdata), .o_wstrb(wstrb), .i_wready(wready),
        .o_busy(busy), .o_done(done), .o_overflow(ovf), .o_word_count(wc)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        wready = (wr_mode == 0) ? ($urandom % 3 != 0) : (wr_mode == 2);
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every accepted write and checks stall stability.
    always @(negedge clk) begin
        if (rst) stall_prev = 0;
        else begin
            if (we) check("byte_ready_in_write", {63'b0, bready}, 0);
            if (stall_prev && we) begin
                check("stall_addr", {32'b0, waddr}, {32'b0, sa});
                check("stall_data", {32'b0, wdata}, {32'b0, sd});
                check("stall_strb", {60'b0, wstrb}, {60'b0, ss});
            end
            if (we && wready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_write: got addr %0h data %0h, expected no write", waddr, wdata);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    check("write_addr", {32'b0, waddr}, {32'b0, e.a});
                    check("write_data", {32'b0, wdata}, {32'b0, e.d});
                    check("write_strb", {60'b0, wstrb}, {60'b0, e.s});
                end
            end
            stall_prev = we && !wready;
            sa = waddr;
            sd = wdata;
            ss = wstrb;
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic l, input logic st);
        int t;
        bvalid = 1;
        bdata = b;
        blast = l;
        start = st;
        for (t = 0; t < 500; t++) begin
            @(negedge clk);
            if (bready) begin
                @(posedge clk);
                #1;
                break;
            end
        end
        start = 0;
        bvalid = 0;
        blast = 0;
        if (t == 500) begin
            n_cmp++;
            n_err++;
            $display("FAIL byte_accept_timeout: byte %0h not accepted, expected acceptance", b);
        end
    endtask

    task automatic run_load(input bq_t bs, input bit stall, input bit rnd);
        int L, nw, t;
        L = bs.size();
        nw = (L + 3) / 4;
        if (nw > 4) nw = 4;
        for (int k = 0; k < nw; k++) begin
            wr_t e;
            e.a = 32'(4 * k);
            e.d = 0;
            e.s = 0;
            for (int j = 0; j < 4; j++)
                if (4 * k + j < L) begin
                    e.d = e.d | (32'(bs[4*k+j]) << (8 * j));
                    e.s = e.s | 4'(1 << j);
                end
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        if (stall) begin
            wr_mode = 1;
            fork
                begin
                    for (int w = 0; w < 100 && !we; w++) @(negedge clk);
                    repeat (3) @(posedge clk);
                    wr_mode = 2;
                end
            join_none
        end
        start = 1;
        @(posedge clk);
        #1;
        start = 0;
        for (int i = 0; i < L; i++) begin
            send_byte(bs[i], i == L - 1, i != L - 1 && ((i == 1) || (rnd && $urandom % 5 == 0)));
            if (rnd && $urandom % 4 == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end
        for (t = 0; t < 300 && !done; t++) @(negedge clk);
        check("done", {63'b0, done}, 1);
        check("overflow", {63'b0, ovf}, {63'b0, L > 16});
        check("word_count", {61'b0, wc}, 64'(nw));
        check("pending_writes", 64'(exp_q.size()), 0);
        check("ready_in_done", {63'b0, bready}, 0);
        exp_q.delete();
    endtask

    initial begin
        bq_t b;
        repeat (3) @(posedge clk);
        #1;
        rst = 0;
        @(negedge clk);
        check("rst_we", {63'b0, we}, 0);
        check("rst_ready", {63'b0, bready}, 0);
        check("rst_busy", {63'b0, busy}, 0);
        check("rst_done", {63'b0, done}, 0);
        check("rst_ovf", {63'b0, ovf}, 0);
        check("rst_outs", {wdata, waddr}, 0);
        check("rst_strb_wc", {57'b0, wstrb, wc}, 0);

        wr_mode = 2;
        b = {};
        for (int i = 1; i <= 8; i++) b.push_back(8'(i));
        run_load(b, 0, 0);

        b = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        run_load(b, 0, 0);

        b = {};
        for (int i = 1; i <= 8; i++) b.push_back(8'(i));
        run_load(b, 1, 0);

        wr_mode = 2;
        b = {};
        for (int i = 0; i < 20; i++) b.push_back(8'($urandom));
        run_load(b, 0, 0);

        b = {};
        for (int i = 0; i < 16; i++) b.push_back(8'($urandom));
        run_load(b, 0, 1);

        wr_mode = 0;
        for (int r = 0; r < 12; r++) begin
            int len;
            len = $urandom_range(1, 24);
            b = {};
            for (int i = 0; i < len; i++) b.push_back(8'($urandom));
            run_load(b, 0, 1);
        end

        // Reset while a write is pending must discard the word.
        @(posedge clk);
        #1;
        wr_mode = 1;
        start = 1;
        @(posedge clk);
        #1;
        start = 0;
        for (int i = 0; i < 4; i++) send_byte(8'h10 + 8'(i), 0, 0);
        for (int w = 0; w < 100 && !we; w++) @(negedge clk);
        check("we_before_reset", {63'b0, we}, 1);
        @(posedge clk);
        #1;
        rst = 1;
        @(posedge clk);
        #1;
        rst = 0;
        @(negedge clk);
        check("post_rst_we", {63'b0, we}, 0);
        check("post_rst_busy", {63'b0, busy}, 0);
        check("post_rst_wc", {61'b0, wc}, 0);
        check("post_rst_data", {32'b0, wdata}, 0);
        wr_mode = 0;
        b = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        run_load(b, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
